// File: rtl/wb_regbank_arbiter_if.sv
// rtl/wb_regbank_arbiter_if.sv - one pipelined 32-bit Wishbone link
//
// Purpose: carries one Wishbone link between a master and a slave.
//   The master modport drives the request side.
//   The slave modport drives the termination side.
// Signals:
//   cyc, stb, we   request qualifiers (master -> slave)
//   adr            word address [ADDR_W+1:2] (master -> slave)
//   sel            byte selects (master -> slave)
//   dat_w          write data (master -> slave)
//   dat_r          read data (slave -> master)
//   ack, err       termination (slave -> master)
//   stall          pipeline stall (slave -> master)
interface wb_regbank_arbiter_if #(
  parameter int ADDR_W = 4
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W+1:2] adr;
  logic [3:0]        sel;
  logic [31:0]       dat_w;
  logic [31:0]       dat_r;
  logic              ack;
  logic              err;
  logic              stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack, err, stall
  );
endinterface

// File: rtl/wb_regbank_arbiter.sv
// rtl/wb_regbank_arbiter.sv - two-master round-robin Wishbone arbiter for a register bank
//
// Purpose: arbitrates two pipelined Wishbone masters onto one register-bank slave.
//   Only one transaction is outstanding at a time.
//   Round-robin grant is held until the slave terminates the transaction.
//   The termination is delivered to the owner as a registered one-cycle pulse.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   m0, m1   slave-side links facing master 0 / master 1
//   s        master-side link facing the register bank
//   grant_o  one-hot current owner, 00 when idle
// Optional feature: define WB_ARB_TIMEOUT_EN to abort a transaction with err.
//   The abort fires after TIMEOUT cycles in ISSUE+WAIT without termination.
module wb_regbank_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wb_regbank_arbiter_if.slave    m0,
  wb_regbank_arbiter_if.slave    m1,
  wb_regbank_arbiter_if.master   s,
  output logic [1:0]             grant_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;  // termination pulse cycle

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("wb_regbank_arbiter: TIMEOUT must be >= 1");
  end

  logic [1:0]        state;
  logic              last;       // master that won the previous arbitration
  logic              owner;      // master owning the current transaction
  logic              abandon_q;  // owner dropped cyc at some point in this transaction
  logic              we_q;
  logic [ADDR_W+1:2] adr_q;
  logic [3:0]        sel_q;
  logic [31:0]       dat_q;
  logic              ack0_q, err0_q, ack1_q, err1_q;
  logic [31:0]       rdat_q;

  logic req0, req1, win0, win1;
  logic busy, term, expire, owner_cyc, deliver, resp_err;

  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;

  // On a tie the master that did not win last time gets the bus.
  assign win0 = (state == ST_IDLE) & req0 & (~req1 | last);
  assign win1 = (state == ST_IDLE) & req1 & (~req0 | ~last);

  assign busy      = (state == ST_ISSUE) | (state == ST_WAIT);
  // A termination during ISSUE counts as acceptance of the strobe.
  assign term      = busy & (s.ack | s.err);
  assign owner_cyc = owner ? m1.cyc : m0.cyc;
  assign deliver   = ~abandon_q & owner_cyc;
  // Err wins over a simultaneous ack; a timeout without termination is an err.
  assign resp_err  = term ? s.err : 1'b1;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] tcnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcnt <= '0;
    end else if (win0 | win1) begin
      tcnt <= '0;
    end else if (busy) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // A termination in the expiry cycle takes precedence over the abort.
  assign expire = busy & ~term & (tcnt == CNT_W'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  // Slave side: cyc/stb are decoded from state so an async reset drops them at once.
  assign s.cyc   = busy;
  assign s.stb   = (state == ST_ISSUE);
  assign s.we    = we_q;
  assign s.adr   = adr_q;
  assign s.sel   = sel_q;
  assign s.dat_w = dat_q;

  // Master side: only the idle-cycle winner (or a non-requester) is unstalled.
  assign m0.stall = (state != ST_IDLE) | (req0 & ~win0);
  assign m1.stall = (state != ST_IDLE) | (req1 & ~win1);
  assign m0.ack   = ack0_q;
  assign m0.err   = err0_q;
  assign m1.ack   = ack1_q;
  assign m1.err   = err1_q;
  assign m0.dat_r = ack0_q ? rdat_q : 32'h0;
  assign m1.dat_r = ack1_q ? rdat_q : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      abandon_q <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      sel_q     <= 4'h0;
      dat_q     <= 32'h0;
      grant_o   <= 2'b00;
      ack0_q    <= 1'b0;
      err0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdat_q    <= 32'h0;
    end else begin
      ack0_q <= 1'b0;
      err0_q <= 1'b0;
      ack1_q <= 1'b0;
      err1_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win0 | win1) begin
            owner     <= win1;
            last      <= win1;
            grant_o   <= {win1, win0};
            we_q      <= win1 ? m1.we    : m0.we;
            adr_q     <= win1 ? m1.adr   : m0.adr;
            sel_q     <= win1 ? m1.sel   : m0.sel;
            dat_q     <= win1 ? m1.dat_w : m0.dat_w;
            abandon_q <= 1'b0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (!owner_cyc) abandon_q <= 1'b1;
          if (term | expire) begin
            state   <= ST_RESP;
            grant_o <= 2'b00;
            rdat_q  <= term ? s.dat_r : 32'h0;
            ack0_q  <= deliver & ~owner & ~resp_err;
            err0_q  <= deliver & ~owner &  resp_err;
            ack1_q  <= deliver &  owner & ~resp_err;
            err1_q  <= deliver &  owner &  resp_err;
          end else if ((state == ST_ISSUE) && !s.stall) begin
            state <= ST_WAIT;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
